// File: rtl/nw_pkg.sv
// Shared definitions for the Needleman-Wunsch job sequencer.
// Holds the direction-matrix encoding, the sequencer state type and the
// error codes reported on err_code.
package nw_pkg;

    // Direction matrix encoding as produced by the scoring grid.
    localparam logic [1:0] TOP_DIR    = 2'b00;
    localparam logic [1:0] LEFT_DIR   = 2'b01;
    localparam logic [1:0] CORNER_DIR = 2'b10;
    localparam logic [1:0] BAD_DIR    = 2'b11;

    typedef enum logic [1:0] {
        StIdle   = 2'b00,
        StLoad   = 2'b01,
        StSettle = 2'b10,
        StTrace  = 2'b11
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_TIMEOUT = 2'b01;
    localparam logic [1:0] ERR_ILLEGAL = 2'b10;
    localparam logic [1:0] ERR_LOST    = 2'b11;

endpackage

// File: rtl/nw_job_sequencer_if.sv
// Bundle of every non-clock/reset signal of nw_job_sequencer.
//   job input : in_valid, in_ready, in_s1, in_s2
//   grid side : grid_s1, grid_s2, grid_clear, grid_valid, dir_x, dir_y, dir_in
//   path out  : path_valid, path_ready, path_x, path_y, path_last
//   status    : busy, done, err, err_code
// modport master is the sequencer; modport slave is its environment
// (job source, scoring grid and path consumer).
interface nw_job_sequencer_if #(
    parameter int unsigned LENGTH      = 10,
    parameter int unsigned CWIDTH      = 2,
    parameter int unsigned CORD_LENGTH = 8
);
    localparam int unsigned SW = LENGTH * CWIDTH;

    logic                   in_valid;
    logic                   in_ready;
    logic [SW-1:0]          in_s1;
    logic [SW-1:0]          in_s2;
    logic [SW-1:0]          grid_s1;
    logic [SW-1:0]          grid_s2;
    logic                   grid_clear;
    logic                   grid_valid;
    logic [CORD_LENGTH-1:0] dir_x;
    logic [CORD_LENGTH-1:0] dir_y;
    logic [1:0]             dir_in;
    logic                   path_valid;
    logic                   path_ready;
    logic [CORD_LENGTH-1:0] path_x;
    logic [CORD_LENGTH-1:0] path_y;
    logic                   path_last;
    logic                   busy;
    logic                   done;
    logic                   err;
    logic [1:0]             err_code;

    modport master (
        input  in_valid, in_s1, in_s2, grid_valid, dir_in, path_ready,
        output in_ready, grid_s1, grid_s2, grid_clear, dir_x, dir_y,
               path_valid, path_x, path_y, path_last, busy, done, err, err_code
    );

    modport slave (
        output in_valid, in_s1, in_s2, grid_valid, dir_in, path_ready,
        input  in_ready, grid_s1, grid_s2, grid_clear, dir_x, dir_y,
               path_valid, path_x, path_y, path_last, busy, done, err, err_code
    );

endinterface

// File: rtl/nw_trace_step.sv
// One traceback step through the direction matrix (purely combinational).
//   x, y     : current cell
//   dir      : direction stored at (y, x)
//   nx, ny   : next cell
//   illegal  : dir is the unused code and no edge guard applied
//   last     : current cell is (0,0)
// On the top row or left column the walk is forced along the edge, so a
// zero coordinate is never decremented regardless of dir.
module nw_trace_step
    import nw_pkg::*;
#(
    parameter int unsigned CORD_LENGTH = 8
) (
    input  logic [CORD_LENGTH-1:0] x,
    input  logic [CORD_LENGTH-1:0] y,
    input  logic [1:0]             dir,
    output logic [CORD_LENGTH-1:0] nx,
    output logic [CORD_LENGTH-1:0] ny,
    output logic                   illegal,
    output logic                   last
);

    localparam logic [CORD_LENGTH-1:0] ONE = CORD_LENGTH'(1);

    always_comb begin
        nx      = x;
        ny      = y;
        illegal = 1'b0;
        last    = (x == '0) && (y == '0);
        if (x == '0) begin
            if (y != '0) ny = y - ONE;
        end else if (y == '0) begin
            nx = x - ONE;
        end else begin
            case (dir)
                TOP_DIR:    ny = y - ONE;
                LEFT_DIR:   nx = x - ONE;
                CORNER_DIR: begin
                    nx = x - ONE;
                    ny = y - ONE;
                end
                default:    illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/nw_job_sequencer.sv
// Runs one Needleman-Wunsch alignment job at a time on the combinational
// scoring grid: accepts a string pair, holds the grid in clear for a cycle,
// waits for the corner cell to settle, then walks the direction matrix from
// (LENGTH-1, LENGTH-1) back to (0,0), streaming coordinates with backpressure.
// Ports:
//   clk, reset : clock, synchronous active-low reset
//   bus        : nw_job_sequencer_if.master (job input, grid side, path output,
//                busy/done/err status)
module nw_job_sequencer
    import nw_pkg::*;
#(
    parameter int unsigned LENGTH        = 10,
    parameter int unsigned CWIDTH        = 2,
    parameter int unsigned CORD_LENGTH   = 8,
    parameter int unsigned SETTLE_CYCLES = 4,
    parameter int unsigned TIMEOUT       = 64
) (
    input  logic                clk,
    input  logic                reset,
    nw_job_sequencer_if.master  bus
);

    localparam int unsigned SW    = LENGTH * CWIDTH;
    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    localparam logic [CORD_LENGTH-1:0] START      = CORD_LENGTH'(LENGTH - 1);
    localparam logic [CNT_W-1:0]       SETTLE_MIN = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0]       CNT_LIMIT  = CNT_W'(TIMEOUT - 1);

    state_t                 state_q, state_d;
    logic [SW-1:0]          s1_q, s1_d;
    logic [SW-1:0]          s2_q, s2_d;
    logic [CORD_LENGTH-1:0] x_q, x_d;
    logic [CORD_LENGTH-1:0] y_q, y_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   done_q, done_d;
    logic                   err_q, err_d;
    logic [1:0]             code_q, code_d;

    logic [CORD_LENGTH-1:0] step_x, step_y;
    logic                   step_illegal, step_last;
    logic                   accept;

    nw_trace_step #(
        .CORD_LENGTH (CORD_LENGTH)
    ) u_step (
        .x       (x_q),
        .y       (y_q),
        .dir     (bus.dir_in),
        .nx      (step_x),
        .ny      (step_y),
        .illegal (step_illegal),
        .last    (step_last)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= StIdle;
            s1_q    <= '0;
            s2_q    <= '0;
            x_q     <= START;
            y_q     <= START;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            code_q  <= ERR_NONE;
        end else begin
            state_q <= state_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
            code_q  <= code_d;
        end
    end

    always_comb begin
        state_d = state_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        x_d     = x_q;
        y_d     = y_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;
        err_d   = 1'b0;
        code_d  = code_q;
        accept  = bus.in_valid && bus.in_ready;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    s1_d    = bus.in_s1;
                    s2_d    = bus.in_s2;
                    x_d     = START;
                    y_d     = START;
                    state_d = StLoad;
                end
            end
            StLoad: begin
                cnt_d   = '0;
                state_d = StSettle;
            end
            StSettle: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q >= SETTLE_MIN && bus.grid_valid) begin
                    state_d = StTrace;
                end else if (cnt_q == CNT_LIMIT) begin
                    err_d   = 1'b1;
                    code_d  = ERR_TIMEOUT;
                    state_d = StIdle;
                end
            end
            StTrace: begin
                // Losing grid_valid outranks any beat offered in the same cycle.
                if (!bus.grid_valid) begin
                    err_d   = 1'b1;
                    code_d  = ERR_LOST;
                    state_d = StIdle;
                end else if (bus.path_ready) begin
                    if (step_last) begin
                        done_d  = 1'b1;
                        state_d = StIdle;
                    end else if (step_illegal) begin
                        err_d   = 1'b1;
                        code_d  = ERR_ILLEGAL;
                        state_d = StIdle;
                    end else begin
                        x_d = step_x;
                        y_d = step_y;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign bus.in_ready   = (state_q == StIdle) && reset;
    assign bus.grid_s1    = s1_q;
    assign bus.grid_s2    = s2_q;
    assign bus.grid_clear = (state_q == StIdle) || (state_q == StLoad);
    assign bus.dir_x      = x_q;
    assign bus.dir_y      = y_q;
    // Gated by grid_valid so no beat can complete in a cycle that aborts.
    assign bus.path_valid = (state_q == StTrace) && bus.grid_valid;
    assign bus.path_x     = x_q;
    assign bus.path_y     = y_q;
    assign bus.path_last  = step_last;
    assign bus.busy       = (state_q != StIdle);
    assign bus.done       = done_q;
    assign bus.err        = err_q;
    assign bus.err_code   = code_q;

endmodule

// File: tb/tb_nw_job_sequencer.sv
// Self-checking bench for nw_job_sequencer (LENGTH=4). Emulates the scoring
// grid with a direction table and a directly driven grid_valid, and checks the
// streamed path against an independent walk of that table.
module tb_nw_job_sequencer;
    import nw_pkg::*;

    localparam int unsigned LENGTH        = 4;
    localparam int unsigned CWIDTH        = 2;
    localparam int unsigned CORD_LENGTH   = 8;
    localparam int unsigned SETTLE_CYCLES = 4;
    localparam int unsigned TIMEOUT       = 64;
    localparam int unsigned SW            = LENGTH * CWIDTH;

    logic clk   = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    nw_job_sequencer_if #(
        .LENGTH      (LENGTH),
        .CWIDTH      (CWIDTH),
        .CORD_LENGTH (CORD_LENGTH)
    ) bus ();

    nw_job_sequencer #(
        .LENGTH        (LENGTH),
        .CWIDTH        (CWIDTH),
        .CORD_LENGTH   (CORD_LENGTH),
        .SETTLE_CYCLES (SETTLE_CYCLES),
        .TIMEOUT       (TIMEOUT)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Emulated direction matrix, indexed [row][column].
    logic [1:0] dirmat [LENGTH][LENGTH];

    always_comb begin
        bus.dir_in = 2'b00;
        if (bus.dir_x < 8'(LENGTH) && bus.dir_y < 8'(LENGTH))
            bus.dir_in = dirmat[bus.dir_y[1:0]][bus.dir_x[1:0]];
    end

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input longint act, input longint exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fill_dirs(input logic [1:0] d);
        for (int r = 0; r < LENGTH; r++)
            for (int c = 0; c < LENGTH; c++) dirmat[r][c] = d;
    endtask

    // ---------------- reference model ----------------
    int e_x[$];
    int e_y[$];
    bit e_illegal;

    // Walk from the far corner: along row 0 / column 0 the only move is toward
    // the origin, elsewhere the stored direction decides.
    task automatic model_path();
        int x = LENGTH - 1;
        int y = LENGTH - 1;
        e_x.delete();
        e_y.delete();
        e_illegal = 0;
        for (int k = 0; k < 2 * LENGTH; k++) begin
            e_x.push_back(x);
            e_y.push_back(y);
            if (x == 0 && y == 0) break;
            if (x == 0) y = y - 1;
            else if (y == 0) x = x - 1;
            else if (dirmat[y][x] == TOP_DIR) y = y - 1;
            else if (dirmat[y][x] == LEFT_DIR) x = x - 1;
            else if (dirmat[y][x] == CORNER_DIR) begin
                x = x - 1;
                y = y - 1;
            end else begin
                e_illegal = 1;
                break;
            end
        end
    endtask

    // ---------------- job driver / collector ----------------
    int r_x[$];
    int r_y[$];
    bit r_last[$];
    bit r_done, r_err;
    int r_code, r_lat, r_gap, r_stall_bad;

    // Offers a job and returns at the sample point just after the accept edge.
    task automatic offer(input logic [SW-1:0] s1, input logic [SW-1:0] s2, input bit keep);
        int cyc = 0;
        bus.in_s1    = s1;
        bus.in_s2    = s2;
        bus.in_valid = 1'b1;
        while (!bus.in_ready && cyc < 200) begin
            tick();
            cyc++;
        end
        check("accept_wait", bus.in_ready, 1);
        tick();
        if (!keep) bus.in_valid = 1'b0;
        check("latch_s1", bus.grid_s1, s1);
        check("latch_s2", bus.grid_s2, s2);
    endtask

    // Collects beats until done/err. r_lat counts cycles with the accept
    // cycle as cycle 0, so the LOAD cycle is 1.
    task automatic collect(input int ready_pct);
        int  cyc = 0;
        int  lb = -100;
        bit  stalled = 0;
        int  px = 0, py = 0;
        r_x.delete();
        r_y.delete();
        r_last.delete();
        r_done = 0; r_err = 0; r_code = 0; r_gap = -1; r_stall_bad = 0;
        r_lat = 1;
        while (!bus.path_valid && !bus.err && r_lat < 300) begin
            tick();
            r_lat++;
        end
        while (cyc < 400) begin
            if (bus.done || bus.err) begin
                r_done = bus.done;
                r_err  = bus.err;
                r_code = int'(bus.err_code);
                r_gap  = cyc - lb;
                break;
            end
            if (stalled && (!bus.path_valid || int'(bus.path_x) != px || int'(bus.path_y) != py))
                r_stall_bad++;
            bus.path_ready = ($urandom_range(99) < ready_pct);
            stalled = 0;
            if (bus.path_valid) begin
                if (bus.path_ready) begin
                    r_x.push_back(int'(bus.path_x));
                    r_y.push_back(int'(bus.path_y));
                    r_last.push_back(bus.path_last);
                    if (bus.path_last) lb = cyc;
                end else begin
                    stalled = 1;
                    px = int'(bus.path_x);
                    py = int'(bus.path_y);
                end
            end
            tick();
            cyc++;
        end
        bus.path_ready = 1'b0;
        if (!r_done && !r_err) check("job_end_bound", 0, 1);
    endtask

    task automatic compare_path(input string tag);
        int mism = 0;
        int n;
        model_path();
        n = (r_x.size() < e_x.size()) ? r_x.size() : e_x.size();
        check({tag, " beats"}, r_x.size(), e_x.size());
        for (int i = 0; i < n; i++) begin
            if (r_x[i] != e_x[i] || r_y[i] != e_y[i] ||
                r_last[i] != ((i == e_x.size() - 1) && !e_illegal)) mism++;
        end
        check({tag, " coords"}, mism, 0);
        check({tag, " latency"}, r_lat, SETTLE_CYCLES + 2);
        check({tag, " done"}, r_done, !e_illegal);
        check({tag, " err"}, r_err, e_illegal);
        check({tag, " stall_hold"}, r_stall_bad, 0);
        if (e_illegal) check({tag, " code"}, r_code, ERR_ILLEGAL);
        else check({tag, " done_gap"}, r_gap, 1);
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [1:0] fill;
        int         beats;
        bit         exp_err;
        int         exp_code;
        int         last_x;
        int         last_y;
    } vec_t;

    vec_t tbl[4];

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [SW-1:0] s1, s2;
        int bx[7];
        int by[7];
        int mism;
        int cyc;

        tbl[0] = '{fill: CORNER_DIR, beats: 4, exp_err: 0, exp_code: 0, last_x: 0, last_y: 0};
        tbl[1] = '{fill: TOP_DIR,    beats: 7, exp_err: 0, exp_code: 0, last_x: 0, last_y: 0};
        tbl[2] = '{fill: LEFT_DIR,   beats: 7, exp_err: 0, exp_code: 0, last_x: 0, last_y: 0};
        tbl[3] = '{fill: BAD_DIR,    beats: 1, exp_err: 1, exp_code: 2, last_x: 3, last_y: 3};
        bx = '{3, 3, 3, 3, 2, 1, 0};
        by = '{3, 2, 1, 0, 0, 0, 0};

        bus.in_valid   = 1'b0;
        bus.in_s1      = '0;
        bus.in_s2      = '0;
        bus.grid_valid = 1'b1;
        bus.path_ready = 1'b0;
        fill_dirs(CORNER_DIR);

        // Reset state.
        reset = 1'b0;
        repeat (3) tick();
        check("rst grid_clear", bus.grid_clear, 1);
        check("rst path_valid", bus.path_valid, 0);
        check("rst done", bus.done, 0);
        check("rst err", bus.err, 0);
        check("rst err_code", bus.err_code, 0);
        check("rst grid_s1", bus.grid_s1, 0);
        check("rst dir_x", bus.dir_x, LENGTH - 1);
        check("rst dir_y", bus.dir_y, LENGTH - 1);
        check("rst in_ready", bus.in_ready, 0);
        check("rst busy", bus.busy, 0);
        reset = 1'b1;
        #1;
        check("rst release in_ready", bus.in_ready, 1);
        tick();

        // ACGT / ACGT, all CORNER, no backpressure.
        offer(8'h1B, 8'h1B, 0);
        check("load grid_clear", bus.grid_clear, 1);
        collect(100);
        compare_path("acgt");

        // Uniform-direction table.
        for (int i = 0; i < 4; i++) begin
            fill_dirs(tbl[i].fill);
            offer(SW'($urandom), SW'($urandom), 0);
            collect(70);
            check($sformatf("tbl%0d beats", i), r_x.size(), tbl[i].beats);
            check($sformatf("tbl%0d err", i), r_err, tbl[i].exp_err);
            check($sformatf("tbl%0d done", i), r_done, !tbl[i].exp_err);
            if (r_x.size() > 0) begin
                check($sformatf("tbl%0d last_x", i), r_x[r_x.size() - 1], tbl[i].last_x);
                check($sformatf("tbl%0d last_y", i), r_y[r_y.size() - 1], tbl[i].last_y);
            end
            if (tbl[i].exp_err) check($sformatf("tbl%0d code", i), r_code, tbl[i].exp_code);
            compare_path($sformatf("tbl%0d model", i));
        end

        // Backpressure held 5 cycles at (2,2).
        fill_dirs(CORNER_DIR);
        offer(8'h1B, 8'h1B, 0);
        cyc = 0;
        while (!bus.path_valid && cyc < 50) begin tick(); cyc++; end
        check("stall first beat x", bus.path_x, 3);
        bus.path_ready = 1'b1;
        tick();
        bus.path_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            check("stall valid", bus.path_valid, 1);
            check("stall x", bus.path_x, 2);
            check("stall y", bus.path_y, 2);
            tick();
        end
        r_lat = SETTLE_CYCLES + 2;
        collect(100);
        check("stall rest beats", r_x.size(), 3);
        if (r_x.size() == 3) begin
            check("stall rest b0", r_x[0] * 10 + r_y[0], 22);
            check("stall rest b2", r_x[2] * 10 + r_y[2], 0);
            check("stall rest last", r_last[2], 1);
        end
        check("stall done", r_done, 1);

        // Timeout: grid never valid.
        bus.grid_valid = 1'b0;
        offer(8'h1B, 8'h1B, 0);
        collect(100);
        check("timeout lat", r_lat, TIMEOUT + 2);
        check("timeout err", r_err, 1);
        check("timeout code", r_code, ERR_TIMEOUT);
        check("timeout beats", r_x.size(), 0);
        check("timeout in_ready", bus.in_ready, 1);
        bus.grid_valid = 1'b1;

        // grid_valid lost during TRACE.
        offer(8'h2D, 8'h87, 0);
        cyc = 0;
        while (!bus.path_valid && cyc < 50) begin tick(); cyc++; end
        bus.grid_valid = 1'b0;
        #1;
        check("lost path_valid", bus.path_valid, 0);
        tick();
        check("lost err", bus.err, 1);
        check("lost code", bus.err_code, ERR_LOST);
        check("lost busy", bus.busy, 0);
        bus.grid_valid = 1'b1;
        tick();
        check("lost err pulse", bus.err, 0);

        // Reset for one cycle during TRACE.
        offer(8'h1B, 8'hE4, 0);
        cyc = 0;
        while (!bus.path_valid && cyc < 50) begin tick(); cyc++; end
        reset = 1'b0;
        tick();
        check("mrst path_valid", bus.path_valid, 0);
        check("mrst grid_clear", bus.grid_clear, 1);
        check("mrst busy", bus.busy, 0);
        check("mrst err", bus.err, 0);
        check("mrst in_ready low", bus.in_ready, 0);
        reset = 1'b1;
        #1;
        check("mrst in_ready", bus.in_ready, 1);
        tick();
        check("mrst no err", bus.err, 0);
        offer(8'h1B, 8'h1B, 0);
        collect(100);
        compare_path("after_reset");

        // Back-to-back: second job held on in_valid while the first runs.
        fill_dirs(CORNER_DIR);
        offer(8'h1B, 8'h1B, 1);
        collect(100);
        check("b2b first done", r_done, 1);
        for (int r = 0; r < LENGTH; r++)
            for (int c = 0; c < LENGTH; c++) dirmat[r][c] = (r == 0) ? LEFT_DIR : TOP_DIR;
        bus.in_s1 = 8'hE4;
        bus.in_s2 = 8'h4E;
        tick();
        bus.in_valid = 1'b0;
        check("b2b accepted busy", bus.busy, 1);
        check("b2b grid_s1", bus.grid_s1, 8'hE4);
        collect(100);
        check("b2b beats", r_x.size(), 7);
        mism = 0;
        if (r_x.size() == 7)
            for (int i = 0; i < 7; i++) if (r_x[i] != bx[i] || r_y[i] != by[i]) mism++;
        check("b2b path", mism, 0);
        compare_path("b2b model");

        // Randomized jobs against the model.
        for (int j = 0; j < 30; j++) begin
            for (int r = 0; r < LENGTH; r++)
                for (int c = 0; c < LENGTH; c++)
                    dirmat[r][c] = ($urandom_range(19) == 0) ? BAD_DIR : 2'($urandom_range(2));
            s1 = SW'($urandom);
            s2 = SW'($urandom);
            offer(s1, s2, 0);
            collect($urandom_range(100, 30));
            compare_path($sformatf("rand%0d", j));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
